// File: rtl/counter_irq_ctrl.sv
// rtl/counter_irq_ctrl.sv - overflow/underflow interrupt controller with tallies and optional count snapshot
// Snapshot logic is compiled in only when COUNTER_IRQ_SNAPSHOT_EN is defined.
module counter_irq_ctrl #(
    parameter int N  = 17,
    parameter int CW = 8
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [N-1:0]  Count_in,
    input  logic          Overflow_intr,
    input  logic          Underflow_intr,
    input  logic [1:0]    Irq_mask,
    input  logic [1:0]    Irq_ack,
    input  logic          Cnt_clr,
    input  logic          Snap_ready,
    output logic [1:0]    Irq_pending,
    output logic          Irq_out,
    output logic [CW-1:0] Ovf_cnt,
    output logic [CW-1:0] Unf_cnt,
    output logic          Snap_valid,
    output logic [N-1:0]  Snap_data,
    output logic          Snap_src,
    output logic          Snap_lost
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [1:0]    pending_q, pending_d;
    logic [CW-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [CW-1:0] unf_cnt_q, unf_cnt_d;
    logic [1:0]    evt;

    assign evt = {Underflow_intr, Overflow_intr};

    always_comb begin
        // A new event beats a simultaneous acknowledge.
        pending_d = (pending_q & ~Irq_ack) | evt;

        ovf_cnt_d = ovf_cnt_q;
        if (Cnt_clr) begin
            ovf_cnt_d = {{(CW-1){1'b0}}, Overflow_intr};
        end else if (Overflow_intr && ovf_cnt_q != CNT_MAX) begin
            ovf_cnt_d = ovf_cnt_q + 1'b1;
        end

        unf_cnt_d = unf_cnt_q;
        if (Cnt_clr) begin
            unf_cnt_d = {{(CW-1){1'b0}}, Underflow_intr};
        end else if (Underflow_intr && unf_cnt_q != CNT_MAX) begin
            unf_cnt_d = unf_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pending_q <= '0;
            ovf_cnt_q <= '0;
            unf_cnt_q <= '0;
        end else begin
            pending_q <= pending_d;
            ovf_cnt_q <= ovf_cnt_d;
            unf_cnt_q <= unf_cnt_d;
        end
    end

    assign Irq_pending = pending_q;
    assign Irq_out     = |(pending_q & ~Irq_mask);
    assign Ovf_cnt     = ovf_cnt_q;
    assign Unf_cnt     = unf_cnt_q;

`ifdef COUNTER_IRQ_SNAPSHOT_EN
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} snap_state_t;

    snap_state_t  state_q;
    logic [N-1:0] snap_data_q;
    logic         snap_src_q;
    logic         snap_lost_q;
    logic         any_evt;

    assign any_evt = |evt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            snap_data_q <= '0;
            snap_src_q  <= 1'b0;
            snap_lost_q <= 1'b0;
        end else begin
            if (Cnt_clr) begin
                snap_lost_q <= 1'b0;
            end
            // Overflow wins the source field when both events arrive together.
            case (state_q)
                IDLE: begin
                    if (any_evt) begin
                        snap_data_q <= Count_in;
                        snap_src_q  <= ~Overflow_intr;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (Snap_ready) begin
                        if (any_evt) begin
                            snap_data_q <= Count_in;
                            snap_src_q  <= ~Overflow_intr;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (any_evt) begin
                        snap_lost_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Snap_valid = (state_q == HOLD);
    assign Snap_data  = snap_data_q;
    assign Snap_src   = snap_src_q;
    assign Snap_lost  = snap_lost_q;
`else
    logic snap_unused;
    assign snap_unused = ^{Snap_ready, Count_in};

    assign Snap_valid = 1'b0;
    assign Snap_data  = '0;
    assign Snap_src   = 1'b0;
    assign Snap_lost  = 1'b0;
`endif

endmodule

// File: tb/tb_counter_irq_ctrl.sv
// tb/tb_counter_irq_ctrl.sv - directed self-checking bench for counter_irq_ctrl
module tb_counter_irq_ctrl;

    localparam int N  = 17;
    localparam int CW = 4;
`ifdef COUNTER_IRQ_SNAPSHOT_EN
    localparam bit SN = 1'b1;
`else
    localparam bit SN = 1'b0;
`endif

    logic          Clock = 1'b0;
    logic          Reset;
    logic [N-1:0]  Count_in;
    logic          Overflow_intr, Underflow_intr;
    logic [1:0]    Irq_mask, Irq_ack;
    logic          Cnt_clr, Snap_ready;
    logic [1:0]    Irq_pending;
    logic          Irq_out;
    logic [CW-1:0] Ovf_cnt, Unf_cnt;
    logic          Snap_valid;
    logic [N-1:0]  Snap_data;
    logic          Snap_src, Snap_lost;

    int n_cmp = 0;
    int n_bad = 0;

    counter_irq_ctrl #(.N(N), .CW(CW)) dut (
        .Clock(Clock), .Reset(Reset), .Count_in(Count_in),
        .Overflow_intr(Overflow_intr), .Underflow_intr(Underflow_intr),
        .Irq_mask(Irq_mask), .Irq_ack(Irq_ack), .Cnt_clr(Cnt_clr),
        .Snap_ready(Snap_ready), .Irq_pending(Irq_pending), .Irq_out(Irq_out),
        .Ovf_cnt(Ovf_cnt), .Unf_cnt(Unf_cnt), .Snap_valid(Snap_valid),
        .Snap_data(Snap_data), .Snap_src(Snap_src), .Snap_lost(Snap_lost)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        Overflow_intr  = 1'b0;
        Underflow_intr = 1'b0;
        Irq_ack        = 2'b00;
        Cnt_clr        = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Count_in = '0; Overflow_intr = 1'b0; Underflow_intr = 1'b0;
        Irq_mask = 2'b00; Irq_ack = 2'b00; Cnt_clr = 1'b0; Snap_ready = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        check("rst_pending", Irq_pending, 0);
        check("rst_irq", Irq_out, 0);
        check("rst_ovf", Ovf_cnt, 0);
        check("rst_unf", Unf_cnt, 0);
        check("rst_valid", Snap_valid, 0);
        check("rst_data", Snap_data, 0);
        check("rst_src", Snap_src, 0);
        check("rst_lost", Snap_lost, 0);

        // First overflow captures the maximum count
        Count_in = 17'h1FFFF; Overflow_intr = 1'b1;
        tick();
        check("s1_pending", Irq_pending, 2'b01);
        check("s1_irq", Irq_out, 1);
        check("s1_ovf", Ovf_cnt, 1);
        check("s1_valid", Snap_valid, SN);
        check("s1_data", Snap_data, SN ? 17'h1FFFF : 0);
        check("s1_src", Snap_src, 0);

        // Set beats ack; event while held without ready is lost
        Irq_ack = 2'b01; Overflow_intr = 1'b1; Count_in = 17'h00123;
        tick();
        check("s2_pend_setwins", Irq_pending, 2'b01);
        check("s2_ovf", Ovf_cnt, 2);
        check("s2_lost", Snap_lost, SN);
        check("s2_data_kept", Snap_data, SN ? 17'h1FFFF : 0);
        Irq_ack = 2'b01;
        tick();
        check("s2_pend_acked", Irq_pending, 0);
        check("s2_irq_acked", Irq_out, 0);
        Cnt_clr = 1'b1; Snap_ready = 1'b1;
        tick();
        Snap_ready = 1'b0;
        check("clr_ovf", Ovf_cnt, 0);
        check("clr_lost", Snap_lost, 0);
        check("ready_idle", Snap_valid, 0);

        // Both events together: overflow has priority as source
        Count_in = 17'd5; Overflow_intr = 1'b1; Underflow_intr = 1'b1;
        tick();
        check("s3_pending", Irq_pending, 2'b11);
        check("s3_ovf", Ovf_cnt, 1);
        check("s3_unf", Unf_cnt, 1);
        check("s3_valid", Snap_valid, SN);
        check("s3_src", Snap_src, 0);
        check("s3_data", Snap_data, SN ? 17'd5 : 0);
        Count_in = 17'd9; Underflow_intr = 1'b1;
        tick();
        check("s3_lost", Snap_lost, SN);
        check("s3_data_kept", Snap_data, SN ? 17'd5 : 0);
        check("s3_unf2", Unf_cnt, 2);

        // Ready plus event while held: recapture, no loss change
        Snap_ready = 1'b1; Count_in = 17'd0; Underflow_intr = 1'b1;
        tick();
        Snap_ready = 1'b0;
        check("s4_valid", Snap_valid, SN);
        check("s4_data", Snap_data, 0);
        check("s4_src", Snap_src, SN);
        check("s4_lost", Snap_lost, SN);
        check("s4_unf3", Unf_cnt, 3);

        // Saturation at 2^CW-1
        Irq_ack = 2'b11;
        tick();
        for (int i = 0; i < 20; i++) begin
            Overflow_intr = 1'b1;
            tick();
            if (i == 12) check("sat_13", Ovf_cnt, 14);
        end
        check("sat_ovf", Ovf_cnt, 15);
        Cnt_clr = 1'b1;
        tick();
        check("sat_clr_ovf", Ovf_cnt, 0);
        check("sat_clr_unf", Unf_cnt, 0);
        check("sat_clr_lost", Snap_lost, 0);
        Cnt_clr = 1'b1; Overflow_intr = 1'b1;
        tick();
        check("clr_evt_ovf", Ovf_cnt, 1);

        // Masking and reset while held
        Irq_ack = 2'b11;
        tick();
        Irq_mask = 2'b10; Underflow_intr = 1'b1;
        tick();
        check("s6_pending", Irq_pending, 2'b10);
        check("s6_irq_masked", Irq_out, 0);
        Irq_mask = 2'b00;
        #1;
        check("s6_irq_unmasked", Irq_out, 1);
        check("s6_valid", Snap_valid, SN);
        Reset = 1'b1; Overflow_intr = 1'b1; Underflow_intr = 1'b1; Count_in = 17'h0AAAA;
        tick();
        Reset = 1'b0;
        check("s6_rst_pending", Irq_pending, 0);
        check("s6_rst_irq", Irq_out, 0);
        check("s6_rst_ovf", Ovf_cnt, 0);
        check("s6_rst_unf", Unf_cnt, 0);
        check("s6_rst_valid", Snap_valid, 0);
        check("s6_rst_data", Snap_data, 0);
        check("s6_rst_src", Snap_src, 0);
        check("s6_rst_lost", Snap_lost, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_irq_ctrl.md
COUNTER_IRQ_CTRL -- requirements
Module: counter_irq_ctrl

Interface
REQ-001 Parameter N, default 17: width of the captured count value; equals the upstream counter width.
REQ-002 Parameter CW, default 8: width of each event-tally register.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows (clock and reset first).
- Clock  input  1  sole clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Count_in  input  N  counter value from the upstream counter's Count_out.
- Overflow_intr  input  1  one-cycle overflow event pulse.
- Underflow_intr  input  1  one-cycle underflow event pulse.
- Irq_mask  input  2  per-source mask; bit0 = overflow, bit1 = underflow; 1 = masked.
- Irq_ack  input  2  write-1-to-clear for Irq_pending, per bit.
- Cnt_clr  input  1  clears both tallies and Snap_lost.
- Snap_ready  input  1  consumer accepts the snapshot.
- Irq_pending  output  2  sticky per-source event flags.
- Irq_out  output  1  combined interrupt request.
- Ovf_cnt  output  CW  saturating overflow tally.
- Unf_cnt  output  CW  saturating underflow tally.
- Snap_valid  output  1  snapshot available.
- Snap_data  output  N  Count_in captured at the event.
- Snap_src  output  1  snapshot source; 0 = overflow, 1 = underflow.
- Snap_lost  output  1  sticky flag: an event was dropped while a snapshot was held.

Function
REQ-004 An event pulse in cycle k SHALL set the matching Irq_pending bit, visible from cycle k+1.
REQ-005 Irq_ack[i]=1 SHALL clear Irq_pending[i] on the next edge; if set and ack coincide, set SHALL win.
REQ-006 Irq_out SHALL equal OR(Irq_pending & ~Irq_mask), combinational from registered state; mask changes take effect in the same cycle.
REQ-007 Each event SHALL increment its tally by 1, saturating at 2^CW-1 without wrapping.
REQ-008 Cnt_clr SHALL zero both tallies and Snap_lost; an event coinciding with Cnt_clr SHALL leave that tally at 1.
REQ-009 Both events in the same cycle SHALL set both pending bits and increment both tallies.
REQ-010 The snapshot FSM SHALL have states IDLE and HOLD; Snap_valid SHALL equal (state==HOLD).
REQ-011 IDLE with any event: capture Count_in into Snap_data and the source into Snap_src, then go to HOLD; overflow SHALL take priority when both events occur.
REQ-012 HOLD with Snap_ready=1 and no event: go to IDLE.
REQ-013 HOLD with Snap_ready=1 and an event in the same cycle: capture the new snapshot and stay in HOLD; no loss.
REQ-014 HOLD with Snap_ready=0 and an event: keep Snap_data and Snap_src unchanged, and set Snap_lost.
REQ-015 Snap_data and Snap_src SHALL remain stable while Snap_valid=1 and Snap_ready=0.

Reset
REQ-016 Reset SHALL have priority over all other inputs.
REQ-017 On reset, all outputs SHALL go to 0: Irq_pending=0, Ovf_cnt=0, Unf_cnt=0, Snap_data=0, Snap_src=0, Snap_lost=0, and FSM=IDLE; Irq_out is therefore 0.
REQ-018 Reset mid-HOLD SHALL discard the pending snapshot; events coinciding with Reset SHALL be ignored.

Configuration
REQ-019 Macro COUNTER_IRQ_SNAPSHOT_EN SHALL compile the snapshot logic in or out.
- Defined: REQ-010 to REQ-015 apply.
- Undefined: no FSM or snapshot registers; Snap_valid, Snap_data, Snap_src and Snap_lost SHALL be tied to 0; Snap_ready is ignored; all other behaviour is unchanged.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Reset, then an Overflow_intr pulse with Count_in=17'h1FFFF, Irq_mask=0 -> next cycle Irq_pending=2'b01, Irq_out=1, Ovf_cnt=1, Snap_valid=1, Snap_data=17'h1FFFF, Snap_src=0.
- Irq_ack=2'b01 in the same cycle as a new overflow pulse -> Irq_pending[0] stays 1; Irq_ack=2'b01 alone -> Irq_pending=0 and Irq_out=0.
- Both pulses together, Count_in=5, Snap_ready=0 -> Irq_pending=2'b11, both tallies +1, Snap_src=0; a further underflow pulse -> Snap_lost=1 and Snap_data still 5.
- Hold Snap_ready=1 with an underflow pulse while in HOLD, Count_in=0 -> stays HOLD, Snap_data=0, Snap_src=1, Snap_lost unchanged.
- CW=4, 20 overflow pulses -> Ovf_cnt=15; then Cnt_clr -> Ovf_cnt=0.
- Irq_mask=2'b10 with an underflow pulse -> Irq_pending=2'b10, Irq_out=0; Reset asserted while in HOLD -> next cycle all outputs are 0.
